// File: rtl/serial_word_transmitter.sv
// serial_word_transmitter: WIDTH-bit valid/ready word serialiser, one bit per bit_strobe, MSB- or LSB-first; optional ACK slot via SERIAL_TX_ACK_EN.
// Latency: first bit on out the cycle after load; each next bit the cycle after its strobe; done one cycle after the final strobe.
// Backpressure: in_ready is high only in IDLE (including the done cycle, so back-to-back loads are legal); abort overrides everything.
module serial_word_transmitter #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             bit_strobe,
   input  logic             abort,
   input  logic             ack_in,
   output logic             out,
   output logic             out_oe,
   output logic             busy,
   output logic             done,
   output logic             nack
);

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
`ifdef SERIAL_TX_ACK_EN
      S_IDLE,
      S_SHIFT,
      S_ACK
`else
      S_IDLE,
      S_SHIFT
`endif
   } state_t;

   // State and registered outputs
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_shreg;
   logic             r_out;
   logic             r_oe;
   logic             r_busy;
   logic             r_done;

   // Next-state values
   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic             w_out_nxt;
   logic             w_oe_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;

   // Bit selection helpers
   logic             w_first_bit;
   logic [WIDTH-1:0] w_rotated;
   logic             w_next_bit;

`ifdef SERIAL_TX_ACK_EN
   logic             r_nack;
   logic             w_nack_nxt;
`else
   // The acknowledge slot does not exist in this build; the input is tied off internally.
   logic             w_unused_ack;
   assign w_unused_ack = ack_in;
`endif

   // The word is rotated rather than shifted so every stored bit stays live;
   // the bit about to go out is always the one adjacent to the current one.
   assign w_first_bit = (MSB_FIRST != 0) ? in_data[WIDTH-1] : in_data[0];
   assign w_rotated   = (MSB_FIRST != 0) ? {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]}
                                         : {r_shreg[0], r_shreg[WIDTH-1:1]};
   assign w_next_bit  = (MSB_FIRST != 0) ? w_rotated[WIDTH-1] : w_rotated[0];

   // Next-state and next-output logic; abort has priority over every state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shreg_nxt = r_shreg;
      w_out_nxt   = r_out;
      w_oe_nxt    = r_oe;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
`ifdef SERIAL_TX_ACK_EN
      w_nack_nxt  = r_nack;
`endif
      if (abort) begin
         // Drop the word silently: no done, nack left as it was.
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_out_nxt   = 1'b0;
         w_oe_nxt    = 1'b0;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // in_ready is implied by being in IDLE; bit_strobe is ignored here.
               if (in_valid) begin
                  w_state_nxt = S_SHIFT;
                  w_cnt_nxt   = '0;
                  w_shreg_nxt = in_data;
                  w_out_nxt   = w_first_bit;
                  w_oe_nxt    = 1'b1;
                  w_busy_nxt  = 1'b1;
`ifdef SERIAL_TX_ACK_EN
                  w_nack_nxt  = 1'b0;
`endif
               end
            end
            S_SHIFT: begin
               if (bit_strobe) begin
                  if (r_cnt != LAST) begin
                     w_cnt_nxt   = r_cnt + CNT_W'(1);
                     w_shreg_nxt = w_rotated;
                     w_out_nxt   = w_next_bit;
                  end else begin
`ifdef SERIAL_TX_ACK_EN
                     // Release the line for the receiver's acknowledge bit.
                     w_state_nxt = S_ACK;
                     w_out_nxt   = 1'b0;
                     w_oe_nxt    = 1'b0;
`else
                     w_state_nxt = S_IDLE;
                     w_cnt_nxt   = '0;
                     w_out_nxt   = 1'b0;
                     w_oe_nxt    = 1'b0;
                     w_busy_nxt  = 1'b0;
                     w_done_nxt  = 1'b1;
`endif
                  end
               end
            end
`ifdef SERIAL_TX_ACK_EN
            S_ACK: begin
               if (bit_strobe) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_nack_nxt  = ack_in;
               end
            end
`endif
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_out_nxt   = 1'b0;
               w_oe_nxt    = 1'b0;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State register and registered outputs, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_shreg <= '0;
         r_out   <= 1'b0;
         r_oe    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shreg <= w_shreg_nxt;
         r_out   <= w_out_nxt;
         r_oe    <= w_oe_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

`ifdef SERIAL_TX_ACK_EN
   // Acknowledge result, held until the next load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nack <= 1'b0;
      end else begin
         r_nack <= w_nack_nxt;
      end
   end

   assign nack = r_nack;
`else
   assign nack = 1'b0;
`endif

   assign in_ready = (r_state == S_IDLE);
   assign out      = r_out;
   assign out_oe   = r_oe;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Bench for serial_word_transmitter: three instances (8-bit MSB-first, 8-bit LSB-first sharing stimulus, 12-bit MSB-first).
// Expected bit streams are pushed to per-instance queues at load time and popped as each bit appears on out.
// Adapts to SERIAL_TX_ACK_EN for the acknowledge slot and nack behaviour.
module tb_serial_word_transmitter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  ab_data = '0;
   logic        ab_valid = 1'b0;
   logic        ab_strobe = 1'b0;
   logic        abort = 1'b0;
   logic        ack_in = 1'b0;
   logic [11:0] c_data = '0;
   logic        c_valid = 1'b0;
   logic        c_strobe = 1'b0;

   logic a_rdy, a_out, a_oe, a_busy, a_done, a_nack;
   logic b_rdy, b_out, b_oe, b_busy, b_done, b_nack;
   logic c_rdy, c_out, c_oe, c_busy, c_done, c_nack;

   bit q_a[$];
   bit q_b[$];
   bit q_c[$];
   int n_cmp = 0;
   int n_err = 0;
   logic exp_nack = 1'b0;

   always #5 clk = ~clk;

   serial_word_transmitter #(.WIDTH(8), .MSB_FIRST(1)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(ab_data), .in_valid(ab_valid), .in_ready(a_rdy),
      .bit_strobe(ab_strobe), .abort(abort), .ack_in(ack_in), .out(a_out), .out_oe(a_oe),
      .busy(a_busy), .done(a_done), .nack(a_nack));

   serial_word_transmitter #(.WIDTH(8), .MSB_FIRST(0)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(ab_data), .in_valid(ab_valid), .in_ready(b_rdy),
      .bit_strobe(ab_strobe), .abort(abort), .ack_in(ack_in), .out(b_out), .out_oe(b_oe),
      .busy(b_busy), .done(b_done), .nack(b_nack));

   serial_word_transmitter #(.WIDTH(12), .MSB_FIRST(1)) u_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_rdy),
      .bit_strobe(c_strobe), .abort(abort), .ack_in(ack_in), .out(c_out), .out_oe(c_oe),
      .busy(c_busy), .done(c_done), .nack(c_nack));

   task automatic push_ab(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) q_a.push_back(d[i]);
      for (int i = 0; i < 8; i++) q_b.push_back(d[i]);
   endtask

   task automatic push_c(input logic [11:0] d);
      for (int i = 11; i >= 0; i--) q_c.push_back(d[i]);
   endtask

   // One full word through the shared 8-bit pair, strobes every gap cycles
   task automatic send_ab(input logic [7:0] d, input logic ackv, input int gap);
      bit ea, eb;
      @(negedge clk);
      n_cmp++;
      if ({a_rdy, b_rdy} !== 2'b11) begin
         n_err++; $display("FAIL ready_before_load got=%b exp=11", {a_rdy, b_rdy});
      end
      ab_data = d; ab_valid = 1'b1; push_ab(d);
      @(negedge clk);
      ab_valid = 1'b0; ab_data = ~d;
      exp_nack = 1'b0;
      n_cmp++;
      if ({a_rdy, a_oe, a_busy, a_nack, b_nack} !== 5'b01100) begin
         n_err++; $display("FAIL load_flags word=%h got=%b exp=01100", d, {a_rdy, a_oe, a_busy, a_nack, b_nack});
      end
      for (int i = 0; i < 8; i++) begin
         ea = q_a.pop_front();
         eb = q_b.pop_front();
         n_cmp++;
         if ({a_out, b_out, a_oe, b_oe, a_busy, a_done} !== {ea, eb, 4'b1110}) begin
            n_err++;
            $display("FAIL bit word=%h idx=%0d got out_a/out_b/oe_a/oe_b/busy/done=%b exp=%b",
                     d, i, {a_out, b_out, a_oe, b_oe, a_busy, a_done}, {ea, eb, 4'b1110});
         end
         ab_strobe = 1'b1;
         @(negedge clk);
         ab_strobe = 1'b0;
         if (i < 7) repeat (gap - 1) @(negedge clk);
      end
`ifdef SERIAL_TX_ACK_EN
      n_cmp++;
      if ({a_out, a_oe, a_busy, a_done, b_oe} !== 5'b00100) begin
         n_err++; $display("FAIL ack_slot word=%h got=%b exp=00100", d, {a_out, a_oe, a_busy, a_done, b_oe});
      end
      ack_in = ackv;
      repeat (gap - 1) @(negedge clk);
      ab_strobe = 1'b1;
      @(negedge clk);
      ab_strobe = 1'b0; ack_in = 1'b0;
      exp_nack = ackv;
`endif
      n_cmp++;
      if ({a_done, b_done, a_busy, a_oe, a_rdy, a_out} !== 6'b110010) begin
         n_err++; $display("FAIL done_cycle word=%h got=%b exp=110010", d, {a_done, b_done, a_busy, a_oe, a_rdy, a_out});
      end
      n_cmp++;
      if ({a_nack, b_nack} !== {exp_nack, exp_nack}) begin
         n_err++; $display("FAIL nack word=%h got=%b exp=%b", d, {a_nack, b_nack}, {exp_nack, exp_nack});
      end
      @(negedge clk);
      n_cmp++;
      if ({a_done, b_done, a_busy} !== 3'b000) begin
         n_err++; $display("FAIL done_width word=%h got=%b exp=000", d, {a_done, b_done, a_busy});
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({a_out, a_oe, a_busy, a_done, a_nack, b_out, b_oe, b_busy, b_done, b_nack,
           c_out, c_oe, c_busy, c_done, c_nack} !== 15'd0) begin
         n_err++; $display("FAIL reset_outputs got=%b exp=0", {a_out, a_oe, a_busy, a_done, a_nack,
                  b_out, b_oe, b_busy, b_done, b_nack, c_out, c_oe, c_busy, c_done, c_nack});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({a_rdy, b_rdy, c_rdy, a_busy} !== 4'b1110) begin
         n_err++; $display("FAIL reset_ready got=%b exp=1110", {a_rdy, b_rdy, c_rdy, a_busy});
      end
   endtask

   task automatic test_bit_order;
      send_ab(8'hA5, 1'b0, 4);
      send_ab(8'h01, 1'b0, 4);
   endtask

   task automatic test_ack;
      send_ab(8'h3C, 1'b1, 4);
      send_ab(8'h3C, 1'b0, 2);
      send_ab(8'h3C, 1'b1, 1);
   endtask

   task automatic test_back_to_back;
      bit e;
      @(negedge clk);
      c_data = 12'hFFF; c_valid = 1'b1; push_c(12'hFFF);
      @(negedge clk);
      c_valid = 1'b0; c_data = 12'h000;
      // Strobe held high: one advance per cycle
      for (int i = 0; i < 12; i++) begin
         e = q_c.pop_front();
         n_cmp++;
         if ({c_out, c_oe, c_busy} !== {e, 2'b11}) begin
            n_err++; $display("FAIL w12_first idx=%0d got=%b exp=%b", i, {c_out, c_oe, c_busy}, {e, 2'b11});
         end
         c_strobe = 1'b1;
         @(negedge clk);
      end
`ifdef SERIAL_TX_ACK_EN
      n_cmp++;
      if ({c_oe, c_busy, c_done} !== 3'b010) begin
         n_err++; $display("FAIL w12_ack_slot got=%b exp=010", {c_oe, c_busy, c_done});
      end
      @(negedge clk);
`endif
      c_strobe = 1'b0;
      n_cmp++;
      if ({c_done, c_rdy, c_busy, c_nack} !== 4'b1100) begin
         n_err++; $display("FAIL w12_done got=%b exp=1100", {c_done, c_rdy, c_busy, c_nack});
      end
      c_data = 12'hA5C; c_valid = 1'b1; push_c(12'hA5C);
      @(negedge clk);
      c_valid = 1'b0; c_data = 12'hFFF;
      n_cmp++;
      if ({c_busy, c_oe, c_done, c_rdy} !== 4'b1100) begin
         n_err++; $display("FAIL w12_no_gap got=%b exp=1100", {c_busy, c_oe, c_done, c_rdy});
      end
      for (int i = 0; i < 12; i++) begin
         e = q_c.pop_front();
         n_cmp++;
         if ({c_out, c_oe, c_busy} !== {e, 2'b11}) begin
            n_err++; $display("FAIL w12_second idx=%0d got=%b exp=%b", i, {c_out, c_oe, c_busy}, {e, 2'b11});
         end
         c_strobe = 1'b1;
         @(negedge clk);
         c_strobe = 1'b0;
         if (i < 11) @(negedge clk);
      end
`ifdef SERIAL_TX_ACK_EN
      c_strobe = 1'b1;
      @(negedge clk);
      c_strobe = 1'b0;
`endif
      n_cmp++;
      if ({c_done, c_busy, c_oe, c_rdy} !== 4'b1001) begin
         n_err++; $display("FAIL w12_second_done got=%b exp=1001", {c_done, c_busy, c_oe, c_rdy});
      end
   endtask

   task automatic test_abort;
      @(negedge clk);
      ab_data = 8'hFF; ab_valid = 1'b1;
      @(negedge clk);
      ab_valid = 1'b0;
      exp_nack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ab_strobe = 1'b1;
         @(negedge clk);
         ab_strobe = 1'b0;
         @(negedge clk);
      end
      n_cmp++;
      if ({a_busy, a_oe, a_out, b_out} !== 4'b1111) begin
         n_err++; $display("FAIL abort_pre got=%b exp=1111", {a_busy, a_oe, a_out, b_out});
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++;
      if ({a_out, a_oe, a_busy, a_done, a_rdy, b_oe, b_busy, b_done} !== 8'b00001000) begin
         n_err++; $display("FAIL abort_state got=%b exp=00001000", {a_out, a_oe, a_busy, a_done, a_rdy, b_oe, b_busy, b_done});
      end
      n_cmp++;
      if (a_nack !== exp_nack) begin
         n_err++; $display("FAIL abort_nack got=%b exp=%b", a_nack, exp_nack);
      end
      @(negedge clk);
      n_cmp++;
      if ({a_done, b_done} !== 2'b00) begin
         n_err++; $display("FAIL abort_no_done got=%b exp=00", {a_done, b_done});
      end
      // Abort in IDLE blocks a simultaneous load
      abort = 1'b1; ab_valid = 1'b1; ab_data = 8'h80;
      @(negedge clk);
      abort = 1'b0; ab_valid = 1'b0;
      n_cmp++;
      if ({a_busy, a_oe, a_rdy, b_busy} !== 4'b0010) begin
         n_err++; $display("FAIL abort_blocks_load got=%b exp=0010", {a_busy, a_oe, a_rdy, b_busy});
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      ab_data = 8'hC3; ab_valid = 1'b1;
      @(negedge clk);
      ab_valid = 1'b0;
      ab_strobe = 1'b1;
      @(negedge clk);
      ab_strobe = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({a_busy, a_oe, a_out} !== 3'b111) begin
         n_err++; $display("FAIL midword_pre got=%b exp=111", {a_busy, a_oe, a_out});
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_out, a_oe, a_busy, a_done, a_nack, b_out, b_oe, b_busy} !== 8'd0) begin
         n_err++; $display("FAIL async_reset got=%b exp=0", {a_out, a_oe, a_busy, a_done, a_nack, b_out, b_oe, b_busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({a_rdy, b_rdy, a_busy, a_done} !== 4'b1100) begin
         n_err++; $display("FAIL reset_release got=%b exp=1100", {a_rdy, b_rdy, a_busy, a_done});
      end
      send_ab(8'h5A, 1'b0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_bit_order();
      test_ack();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      n_cmp++;
      if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
         n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", q_a.size() + q_b.size() + q_c.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
